// File: rtl/life_pkg.sv
// Shared types for the life neighbourhood pipeline: neighbour vector layout and window FSM states.
package life_pkg;

    typedef logic [7:0] nbr_t;

    localparam int unsigned NB_NW = 0;
    localparam int unsigned NB_N  = 1;
    localparam int unsigned NB_NE = 2;
    localparam int unsigned NB_W  = 3;
    localparam int unsigned NB_E  = 4;
    localparam int unsigned NB_SW = 5;
    localparam int unsigned NB_S  = 6;
    localparam int unsigned NB_SE = 7;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/life_linebuf.sv
// Cell delay line of DEPTH taps (incoming cell is tap 0); exposes the three 3-cell rows of the window.
module life_linebuf #(
    parameter int unsigned STRIDE = 16,
    parameter int unsigned DEPTH  = 2 * STRIDE + 3
) (
    input  logic       clk,
    input  logic       en,
    input  logic       din,
    output logic [2:0] row_s_c,
    output logic [2:0] row_c_c,
    output logic [2:0] row_n_c
);

    // Tap 0 is din itself, so only DEPTH-1 cells need storage.
    logic [DEPTH-2:0] line;

    always_ff @(posedge clk) begin
        if (en) begin
            line <= {line[DEPTH-3:0], din};
        end
    end

    assign row_s_c = {line[1], line[0], din};
    assign row_c_c = line[STRIDE+1:STRIDE-1];
    assign row_n_c = line[2*STRIDE+1:2*STRIDE-1];

endmodule

// File: rtl/life_window.sv
// Raster-order 3x3 neighbourhood generator with dead-padded frame edges.
// Optional LIFE_WINDOW_POP_EN adds out_pop, the live-cell total of the last completed frame.
module life_window
    import life_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_cell,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_self,
    output nbr_t                       out_n,
    output logic [$clog2(HEIGHT)-1:0]  out_row,
    output logic [$clog2(WIDTH)-1:0]   out_col,
    output logic                       out_last
`ifdef LIFE_WINDOW_POP_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] out_pop
`endif
);

    localparam int unsigned CW    = $clog2(WIDTH);
    localparam int unsigned RW    = $clog2(HEIGHT);
    localparam int unsigned DEPTH = 2 * WIDTH + 3;

    state_t        state;
    logic [CW-1:0] in_col, cen_col;
    logic [RW-1:0] in_row, cen_row;

    logic       out_free_c, in_acc_c, flush_load_c, load_c, shift_c, din_c;
    logic [2:0] row_s_c, row_c_c, row_n_c;
    logic       top_c, bot_c, lft_c, rgt_c;
    nbr_t       nbr_c;

    assign out_free_c   = !out_valid || out_ready;
    assign in_ready     = (state == ST_FILL) || ((state == ST_RUN) && out_free_c);
    assign in_acc_c     = in_valid && in_ready;
    // The final window is held until accepted; no further flush load behind it.
    assign flush_load_c = (state == ST_FLUSH) && out_free_c && !(out_valid && out_last);
    assign load_c       = ((state == ST_RUN) && in_acc_c) || flush_load_c;
    assign shift_c      = in_acc_c || flush_load_c;
    assign din_c        = (state == ST_FLUSH) ? 1'b0 : in_cell;

    life_linebuf #(
        .STRIDE (WIDTH),
        .DEPTH  (DEPTH)
    ) u_linebuf (
        .clk     (clk),
        .en      (shift_c),
        .din     (din_c),
        .row_s_c (row_s_c),
        .row_c_c (row_c_c),
        .row_n_c (row_n_c)
    );

    assign top_c = (cen_row == '0);
    assign bot_c = (cen_row == RW'(HEIGHT - 1));
    assign lft_c = (cen_col == '0);
    assign rgt_c = (cen_col == CW'(WIDTH - 1));

    // Neighbours of the centre being loaded, masked to dead outside the frame.
    always_comb begin
        nbr_c        = '0;
        nbr_c[NB_SE] = row_s_c[0] && !bot_c && !rgt_c;
        nbr_c[NB_S]  = row_s_c[1] && !bot_c;
        nbr_c[NB_SW] = row_s_c[2] && !bot_c && !lft_c;
        nbr_c[NB_E]  = row_c_c[0] && !rgt_c;
        nbr_c[NB_W]  = row_c_c[2] && !lft_c;
        nbr_c[NB_NE] = row_n_c[0] && !top_c && !rgt_c;
        nbr_c[NB_N]  = row_n_c[1] && !top_c;
        nbr_c[NB_NW] = row_n_c[2] && !top_c && !lft_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            in_col    <= '0;
            in_row    <= '0;
            cen_col   <= '0;
            cen_row   <= '0;
            out_valid <= 1'b0;
            out_self  <= 1'b0;
            out_n     <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_acc_c) begin
                if (in_col == CW'(WIDTH - 1)) begin
                    in_col <= '0;
                    in_row <= (in_row == RW'(HEIGHT - 1)) ? '0 : in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end

            if (load_c) begin
                out_valid <= 1'b1;
                out_self  <= row_c_c[1];
                out_n     <= nbr_c;
                out_row   <= cen_row;
                out_col   <= cen_col;
                out_last  <= bot_c && rgt_c;
                if (rgt_c) begin
                    cen_col <= '0;
                    cen_row <= bot_c ? '0 : cen_row + RW'(1);
                end else begin
                    cen_col <= cen_col + CW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_FILL: begin
                    if (in_acc_c && (in_row == RW'(1)) && (in_col == '0)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_acc_c && (in_row == RW'(HEIGHT - 1)) && (in_col == CW'(WIDTH - 1))) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (out_valid && out_ready && out_last) begin
                        state <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

`ifdef LIFE_WINDOW_POP_EN
    localparam int unsigned PW = $clog2(WIDTH * HEIGHT + 1);

    logic [PW-1:0] pop_acc;

    // Live-cell tally over accepted windows; published when the frame's last window leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_acc <= '0;
            out_pop <= '0;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                out_pop <= pop_acc + PW'(out_self);
                pop_acc <= '0;
            end else begin
                pop_acc <= pop_acc + PW'(out_self);
            end
        end
    end
`endif

endmodule

// File: tb/tb_life_window.sv
// Directed bench for life_window at WIDTH=HEIGHT=4; windows checked against a coordinate-based model.
module tb_life_window;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_cell;
    logic       out_valid, out_ready, out_self, out_last;
    logic [7:0] out_n;
    logic [1:0] out_row, out_col;
`ifdef LIFE_WINDOW_POP_EN
    logic [4:0] out_pop;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] got_w[16];
    logic [13:0] ref_w[16];
    int          got_cnt;

    always #5 clk = ~clk;

    life_window #(.WIDTH(4), .HEIGHT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cell   (in_cell),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_self  (out_self),
        .out_n     (out_n),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
`ifdef LIFE_WINDOW_POP_EN
        ,
        .out_pop   (out_pop)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cell_at(input logic [15:0] f, input int r, input int c);
        if (r < 0 || r > 3 || c < 0 || c > 3) return 1'b0;
        return f[r * 4 + c];
    endfunction

    // {row, col, last, self, SE S SW E W NE N NW}
    function automatic logic [13:0] model_w(input logic [15:0] f, input int k);
        int r = k / 4;
        int c = k % 4;
        logic [7:0] n;
        n = {cell_at(f, r + 1, c + 1), cell_at(f, r + 1, c), cell_at(f, r + 1, c - 1),
             cell_at(f, r, c + 1), cell_at(f, r, c - 1),
             cell_at(f, r - 1, c + 1), cell_at(f, r - 1, c), cell_at(f, r - 1, c - 1)};
        return {2'(r), 2'(c), (k == 15), cell_at(f, r, c), n};
    endfunction

    // Streams one frame in and collects 16 windows; with stall set, random gaps and backpressure.
    task automatic run_frame(input logic [15:0] frame, input bit stall);
        int          sent = 0;
        int          cyc = 0;
        bit          prev_stall = 0;
        logic [14:0] snap = '0;
        got_cnt = 0;
        while (got_cnt < 16 && cyc < 400) begin
            if (prev_stall)
                check("stall_hold", 32'({out_valid, out_row, out_col, out_last, out_self, out_n}), 32'(snap));
            out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_valid  = (sent < 16) && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_cell   = in_valid && frame[4'(sent)];
            #1;
            if (out_valid && out_ready) begin
                got_w[got_cnt] = {out_row, out_col, out_last, out_self, out_n};
                got_cnt++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            snap = {out_valid, out_row, out_col, out_last, out_self, out_n};
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        in_cell  = 1'b0;
        check("window_count", 32'(got_cnt), 32'd16);
    endtask

    task automatic check_model(input string tag, input logic [15:0] frame);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s_w%0d", tag, k), 32'(got_w[k]), 32'(model_w(frame, k)));
    endtask

    initial begin
        int ones;
        int extra;
        int sent;
        rst = 1'b1; in_valid = 1'b0; in_cell = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_window", 32'({out_self, out_n, out_row, out_col, out_last}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // All-ones frame
        run_frame(16'hFFFF, 0);
        check_model("ones", 16'hFFFF);
        check("ones_00_n", 32'(got_w[0][7:0]), 32'h0D0);
        check("ones_11_n", 32'(got_w[5][7:0]), 32'h0FF);
        ones = 0;
        for (int k = 0; k < 16; k++) ones += int'(got_w[k][9]);
        check("ones_last_count", 32'(ones), 32'd1);
        check("ones_last_33", 32'(got_w[15][9]), 32'd1);

        // Single live cell at row 1, col 1
        run_frame(16'h0020, 0);
        check_model("single", 16'h0020);
        check("single_00_se", 32'(got_w[0][7]), 32'd1);
        check("single_22_nw", 32'(got_w[10][0]), 32'd1);
        check("single_11", 32'(got_w[5][8:0]), 32'h100);
        ones = 0;
        for (int k = 0; k < 16; k++) ones += int'(got_w[k][8]);
        check("single_self_sum", 32'(ones), 32'd1);

        // Vertical blinker in column 1, rows 0-2
        run_frame(16'h0222, 0);
        check_model("blinker", 16'h0222);
        check("blinker_11_n", 32'(got_w[5][7:0]), 32'h042);
        check("blinker_10_cnt", 32'($countones(got_w[4][7:0])), 32'd3);
        check("blinker_12_cnt", 32'($countones(got_w[6][7:0])), 32'd3);

        // Same frame with and without stalls must give identical windows
        run_frame(16'hA5C3, 0);
        for (int k = 0; k < 16; k++) ref_w[k] = got_w[k];
        run_frame(16'hA5C3, 1);
        for (int k = 0; k < 16; k++)
            check($sformatf("stall_w%0d", k), 32'(got_w[k]), 32'(ref_w[k]));
        out_ready = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            extra += int'(out_valid);
        end
        check("no_extra_window", 32'(extra), 32'd0);

        // Reset after 7 cells discards the partial frame
        sent = 0;
        for (int c = 0; c < 50 && sent < 7; c++) begin
            in_valid = 1'b1; in_cell = 1'b1; out_ready = 1'b1;
            #1;
            if (in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_cell = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        run_frame(16'h0000, 0);
        check_model("zero", 16'h0000);

        // Back-to-back frames: all ones then single cell
        run_frame(16'hFFFF, 0);
        check_model("b2b1", 16'hFFFF);
`ifdef LIFE_WINDOW_POP_EN
        check("pop_frame1", 32'(out_pop), 32'd16);
`endif
        run_frame(16'h0020, 0);
        check_model("b2b2", 16'h0020);
`ifdef LIFE_WINDOW_POP_EN
        check("pop_frame2", 32'(out_pop), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
